// File: rtl/corelet_ctrl_if.sv
// corelet_ctrl_if: start/done handshake plus SRAM, L0, OFIFO and SFP control bundle (CORELET_CTRL_PERF_EN adds perf counters)
interface corelet_ctrl_if #(
    parameter int x_addr_bw = 11,
    parameter int p_addr_bw = 11
);
    logic                 start, busy, done;
    logic                 xmem_rd;
    logic [x_addr_bw-1:0] xmem_addr;
    logic                 l0_wr, l0_sel_skid, l0_rd;
    logic [1:0]           inst_w;
    logic                 l0_full, l0_ready;
    logic                 ofifo_rd, ofifo_valid;
    logic                 psum_wr, psum_rd;
    logic [p_addr_bw-1:0] psum_addr;
    logic                 sfu_acc_en, sfu_write_en, out_wr;
    logic [p_addr_bw-1:0] out_addr;
`ifdef CORELET_CTRL_PERF_EN
    logic [31:0]          cyc_cnt, stall_cnt;
    modport master(input start, l0_full, l0_ready, ofifo_valid,
                   output busy, done, xmem_rd, xmem_addr, l0_wr, l0_sel_skid, l0_rd, inst_w,
                   ofifo_rd, psum_wr, psum_rd, psum_addr, sfu_acc_en, sfu_write_en, out_wr, out_addr,
                   cyc_cnt, stall_cnt);
    modport slave(output start, l0_full, l0_ready, ofifo_valid,
                  input busy, done, xmem_rd, xmem_addr, l0_wr, l0_sel_skid, l0_rd, inst_w,
                  ofifo_rd, psum_wr, psum_rd, psum_addr, sfu_acc_en, sfu_write_en, out_wr, out_addr,
                  cyc_cnt, stall_cnt);
`else
    modport master(input start, l0_full, l0_ready, ofifo_valid,
                   output busy, done, xmem_rd, xmem_addr, l0_wr, l0_sel_skid, l0_rd, inst_w,
                   ofifo_rd, psum_wr, psum_rd, psum_addr, sfu_acc_en, sfu_write_en, out_wr, out_addr);
    modport slave(output start, l0_full, l0_ready, ofifo_valid,
                  input busy, done, xmem_rd, xmem_addr, l0_wr, l0_sel_skid, l0_rd, inst_w,
                  ofifo_rd, psum_wr, psum_rd, psum_addr, sfu_acc_en, sfu_write_en, out_wr, out_addr);
`endif
endinterface

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: layer sequencer (weight load, kernel preload, exec/drain, SFP pass); CORELET_CTRL_PERF_EN adds cycle/stall counters
module corelet_ctrl #(
    parameter int row       = 8,
    parameter int col       = 8,
    parameter int len_kij   = 9,
    parameter int len_nij   = 36,
    parameter int x_addr_bw = 11,
    parameter int p_addr_bw = 11,
    parameter int w_base    = 0,
    parameter int a_base    = 128
) (
    input logic clk,
    input logic reset,
    corelet_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LD_W, KLOAD, KFLUSH, EXEC, SFP, FIN} state_t;
    state_t state, state_nx;
    logic [15:0] kij, ic, wc, rc, dc, fc, sk, so, oc, n_fetch, n_rd;
    logic pend, sv, acc_q, lst_q, wen_q, owr_q;
    logic fetch, issue, rd_want, rd_go;
    // next state plus every strobe/address, all decoded from the current state and counters
    always_comb begin
        fetch = state == LD_W || state == EXEC;
        n_fetch = state == LD_W ? 16'(col) : 16'(len_nij);
        n_rd = state == KLOAD ? 16'(col) : 16'(len_nij);
        issue = fetch && ic < n_fetch && !bus.l0_full;
        rd_want = (state == KLOAD || state == EXEC) && rc < n_rd;
        rd_go = rd_want && bus.l0_ready;
        bus.busy = state != IDLE && state != FIN;
        bus.done = state == FIN;
        bus.xmem_rd = issue;
        bus.xmem_addr = issue ? x_addr_bw'((state == LD_W ? 16'(w_base) + kij * 16'(col) : 16'(a_base)) + ic) : '0;
        bus.l0_wr = (sv || pend) && !bus.l0_full;
        bus.l0_sel_skid = sv;
        bus.l0_rd = rd_go;
        bus.inst_w = !rd_go ? 2'b00 : state == KLOAD ? 2'b01 : 2'b10;
        bus.ofifo_rd = state == EXEC && bus.ofifo_valid && dc < 16'(len_nij);
        bus.psum_wr = bus.ofifo_rd;
        bus.psum_rd = state == SFP && so < 16'(len_nij);
        bus.psum_addr = bus.ofifo_rd ? p_addr_bw'(kij * 16'(len_nij) + dc)
                      : bus.psum_rd ? p_addr_bw'(sk * 16'(len_nij) + so) : '0;
        bus.sfu_acc_en = acc_q;
        bus.sfu_write_en = wen_q;
        bus.out_wr = owr_q;
        bus.out_addr = owr_q ? p_addr_bw'(oc) : '0;
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? LD_W : IDLE;
            LD_W:    state_nx = wc == 16'(col) ? KLOAD : LD_W;
            KLOAD:   state_nx = rc == 16'(col) ? KFLUSH : KLOAD;
            KFLUSH:  state_nx = fc == 16'(row + col - 1) ? EXEC : KFLUSH;
            EXEC:    state_nx = !(dc == 16'(len_nij) && wc == 16'(len_nij) && rc == 16'(len_nij)) ? EXEC
                              : kij == 16'(len_kij - 1) ? SFP : LD_W;
            SFP:     state_nx = so == 16'(len_nij) && !lst_q && !wen_q ? FIN : SFP;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // state, per-phase counters (cleared on every transition), skid tracking and SFP strobe pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            {kij, ic, wc, rc, dc, fc, sk, so, oc} <= '0;
            {pend, sv, acc_q, lst_q, wen_q, owr_q} <= '0;
        end else begin
            state <= state_nx;
            pend <= issue;
            sv <= (pend || sv) && bus.l0_full;
            acc_q <= bus.psum_rd;
            lst_q <= bus.psum_rd && sk == 16'(len_kij - 1);
            wen_q <= lst_q;
            owr_q <= wen_q;
            oc <= state == IDLE ? '0 : oc + 16'(owr_q);
            kij <= state == IDLE ? '0 : state == EXEC && state_nx == LD_W ? kij + 16'd1 : kij;
            if (state_nx != state) begin
                {ic, wc, rc, dc, fc, sk, so} <= '0;
            end else begin
                ic <= ic + 16'(issue);
                wc <= wc + 16'(bus.l0_wr);
                rc <= rc + 16'(rd_go);
                dc <= dc + 16'(bus.ofifo_rd);
                fc <= fc + 16'(state == KFLUSH);
                sk <= !bus.psum_rd ? sk : sk == 16'(len_kij - 1) ? '0 : sk + 16'd1;
                so <= so + 16'(bus.psum_rd && sk == 16'(len_kij - 1));
            end
        end
    end
`ifdef CORELET_CTRL_PERF_EN
    logic [31:0] cyc_cnt, stall_cnt;
    // saturating busy-cycle and stall counters, restarted by each accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {cyc_cnt, stall_cnt} <= '0;
        end else if (state == IDLE && bus.start) begin
            {cyc_cnt, stall_cnt} <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'(bus.busy && cyc_cnt != '1);
            stall_cnt <= stall_cnt + 32'((sv || (rd_want && !bus.l0_ready)) && stall_cnt != '1);
        end
    end
    // perf counters onto the bundle
    always_comb begin
        bus.cyc_cnt = cyc_cnt;
        bus.stall_cnt = stall_cnt;
    end
`endif
endmodule

// File: tb/tb_corelet_ctrl.sv
// tb_corelet_ctrl: randomized environment (SRAM, skid reg, L0 FIFO, OFIFO, psum SRAM, SFP) with a layer-level reference model
module tb_corelet_ctrl;
    localparam int ROW = 8, COL = 8, KIJ = 9, NIJ = 36, XBW = 11, PBW = 11, WB = 0, AB = 128, L0D = 16;
    localparam int NP = KIJ * NIJ;
    logic clk = 1'b0;
    logic reset = 1'b1;
    corelet_ctrl_if #(.x_addr_bw(XBW), .p_addr_bw(PBW)) bus();
    corelet_ctrl #(.row(ROW), .col(COL), .len_kij(KIJ), .len_nij(NIJ), .x_addr_bw(XBW), .p_addr_bw(PBW),
                   .w_base(WB), .a_base(AB)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    always #5 clk = ~clk;

    int n_vec, n_err;
    int l0q[$], expw[$];
    int mem[NP], pv[NP], exp_out[NIJ];
    int dout, skid, rdat, acc, latch, nacc, cyc;
    int n_l0w, n_kl, n_ex, n_pr, n_ow, n_done, drain;
    int p_full, ofifo_mode;
    bit running, start_req;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_model(input bit rnd_vals);
        l0q.delete();
        expw.delete();
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i < COL; i++) expw.push_back(WB + k * COL + i);
            for (int n = 0; n < NIJ; n++) expw.push_back(AB + n);
        end
        for (int d = 0; d < NP; d++) begin
            pv[d] = rnd_vals ? int'($urandom_range(200)) - 100 : ((d % NIJ) % 2 == 0 ? -1 : 2);
            mem[d] = 0;
        end
        for (int o = 0; o < NIJ; o++) begin
            int s = 0;
            for (int k = 0; k < KIJ; k++) s += pv[k * NIJ + o];
            exp_out[o] = s > 0 ? s : 0;
        end
        {dout, skid, rdat, acc, latch, nacc} = '0;
        {n_l0w, n_kl, n_ex, n_pr, n_ow, n_done, drain} = '0;
        running = 0;
    endtask

    task automatic cycle();
        bit was;
        int v, din;
        @(negedge clk);
        bus.start = start_req;
        start_req = 0;
        bus.l0_full = l0q.size() >= L0D || $urandom_range(99) < p_full;
        bus.l0_ready = l0q.size() > 0 && $urandom_range(3) != 0;
        bus.ofifo_valid = ofifo_mode == 1 ? cyc % 2 == 1 : $urandom_range(1) == 1;
        #1;
        was = running;
        if (bus.done) begin
            n_done++;
            check("done_while_busy", running, 1);
            check("busy_at_done", bus.busy, 0);
            running = 0;
        end else check("busy", bus.busy, running);
        if (bus.start && !was) running = 1;
        check("xmem_rd_when_full", bus.xmem_rd && bus.l0_full, 0);
        if (bus.l0_rd) begin
            check("l0_rd_ready", bus.l0_ready, 1);
            v = l0q.size() > 0 ? l0q.pop_front() : -1;
            if (bus.inst_w == 2'b01) begin
                n_kl++;
                check("kload_word_is_weight", v >= 0 && v < AB, 1);
            end else begin
                n_ex++;
                check("inst_exec", bus.inst_w, 2);
                check("exec_word_is_act", v >= AB, 1);
            end
        end else check("inst_idle", bus.inst_w, 0);
        if (bus.l0_wr) begin
            check("l0_wr_when_full", bus.l0_full, 0);
            din = bus.l0_sel_skid ? skid : dout;
            check("l0_word", din, expw.size() > 0 ? expw.pop_front() : -1);
            l0q.push_back(din);
            n_l0w++;
        end
        check("ofifo_rd_gate", bus.ofifo_rd && !bus.ofifo_valid, 0);
        if (bus.ofifo_rd) begin
            check("psum_wr", bus.psum_wr, 1);
            check("psum_wr_addr", bus.psum_addr, drain);
            if (drain < NP) mem[drain] = pv[drain];
            drain++;
        end else check("psum_wr_idle", bus.psum_wr, 0);
        if (bus.out_wr) begin
            check("out_addr", bus.out_addr, n_ow);
            check("out_val", latch, n_ow < NIJ ? exp_out[n_ow] : -1);
            n_ow++;
        end
        if (bus.sfu_write_en) begin
            check("acc_per_pixel", nacc, KIJ);
            latch = acc > 0 ? acc : 0;
            acc = 0;
            nacc = 0;
        end
        if (bus.sfu_acc_en) begin
            acc += rdat;
            nacc++;
        end
        if (bus.psum_rd) begin
            check("psum_rd_addr", bus.psum_addr, (n_pr % KIJ) * NIJ + n_pr / KIJ);
            rdat = int'(bus.psum_addr) < NP ? mem[bus.psum_addr] : 0;
            n_pr++;
        end
        skid = dout;
        if (bus.xmem_rd) dout = int'(bus.xmem_addr);
        cyc++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {bus.busy, bus.done, bus.xmem_rd, bus.xmem_addr, bus.l0_wr, bus.l0_sel_skid, bus.l0_rd,
                    bus.inst_w, bus.ofifo_rd, bus.psum_wr, bus.psum_rd, bus.psum_addr, bus.sfu_acc_en,
                    bus.sfu_write_en, bus.out_wr, bus.out_addr}, 0);
    endtask

    task automatic run_layer(input int mode, input int pf, input bit rnd_vals);
        int n;
        ofifo_mode = mode;
        p_full = pf;
        reset_model(rnd_vals);
        start_req = 1;
        n = 0;
        while (n_done == 0 && n < 20000) begin
            cycle();
            if (running && $urandom_range(149) == 0) start_req = 1;
            n++;
        end
        check("layer_timeout", n < 20000, 1);
        repeat (5) cycle();
        check("l0_writes", n_l0w, KIJ * (COL + NIJ));
        check("kload_reads", n_kl, KIJ * COL);
        check("exec_reads", n_ex, NP);
        check("psum_writes", drain, NP);
        check("psum_reads", n_pr, NP);
        check("out_writes", n_ow, NIJ);
        check("done_count", n_done, 1);
    endtask

    initial begin
        int n;
        {bus.start, bus.l0_full, bus.l0_ready, bus.ofifo_valid} = '0;
        start_req = 0;
        cyc = 0;
        #12;
        check_idle_outputs("reset_outputs");
        @(negedge clk);
        reset = 1'b0;
        run_layer(1, 0, 1'b0);
        run_layer(0, 30, 1'b1);
        ofifo_mode = 0;
        p_full = 15;
        reset_model(1'b1);
        start_req = 1;
        n = 0;
        while (!(n_kl >= 3 * COL + COL && n_ex > 0) && n < 20000) begin
            cycle();
            n++;
        end
        check("reach_exec_kij3", n < 20000, 1);
        check("no_done_before_abort", n_done, 0);
        #1 reset = 1'b1;
        #1;
        check_idle_outputs("abort_outputs");
        @(negedge clk);
        reset = 1'b0;
        run_layer(0, 15, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/corelet_ctrl.md
Name: corelet_ctrl

Overview:
Top-level sequencer for the corelet (L0 → MAC array → OFIFO, then SFP) in the weight-stationary conv flow. For each of len_kij kernel positions it loads one weight tile from the shared input SRAM, preloads it into the MAC array, and streams len_nij activations through. It drains all OFIFO psums into the psum SRAM, then runs the SFP accumulate/ReLU pass into the output SRAM. It replaces testbench-driven control signals with one start/done handshake.

Parameters:
row, 8, MAC array rows / L0 width in words
col, 8, MAC array columns / OFIFO width
len_kij, 9, kernel positions (weight tiles)
len_nij, 36, output pixels per tile
x_addr_bw, 11, input SRAM address width
p_addr_bw, 11, psum/output SRAM address width
w_base, 0, weight region base (tile k at w_base + k*col)
a_base, 128, activation region base

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse, begins a full layer
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of the SFP pass
xmem_rd  out  1  input SRAM read enable, 1-cycle latency
xmem_addr  out  x_addr_bw  input SRAM address
l0_wr  out  1  L0 write strobe
l0_sel_skid  out  1  L0 din mux: 1 = skid register, 0 = SRAM dout
l0_rd  out  1  L0 read strobe
inst_w  out  2  01 = kernel load, 10 = execute, 00 = idle
l0_full  in  1  L0 cannot accept a write
l0_ready  in  1  L0 holds at least one readable row
ofifo_rd  out  1  OFIFO pop
ofifo_valid  in  1  OFIFO holds a full psum row
psum_wr / psum_rd  out  1 each  psum SRAM write/read enables
psum_addr  out  p_addr_bw  psum SRAM address
sfu_acc_en  out  1  SFP accumulate strobe
sfu_write_en  out  1  SFP latch-ReLU-and-clear strobe
out_wr  out  1  output SRAM write
out_addr  out  p_addr_bw  output SRAM address

Behaviour:
- Reset (async): state IDLE; all counters 0; every output 0. Reset mid-layer aborts immediately, no partial done.
- start is accepted only in IDLE; it is ignored while busy.
- FSM: IDLE → LD_W → KLOAD → KFLUSH → EXEC → (kij<len_kij-1 ? kij++, LD_W : SFP) → FIN → IDLE.
- LD_W: issue col reads at w_base+kij*col+i, one per cycle, only while l0_full=0. Read data arrives 1 cycle later. If l0_full=1 on arrival, capture it in a 1-entry skid register and stop issuing. Drain the skid first (l0_sel_skid=1) when l0_full falls. Leave the state after col words have been written.
- KLOAD: while l0_ready, pulse l0_rd with inst_w=01, col times. inst_w=00 whenever l0_rd=0.
- KFLUSH: hold 00 for row+col cycles.
- EXEC: activation fetch (a_base+n, n<len_nij) uses the LD_W/skid rules. Concurrently, l0_rd with inst_w=10 whenever l0_ready, len_nij total.
- Drain in EXEC: ofifo_rd=ofifo_valid. Same cycle, psum_wr=1 and psum_addr=kij*len_nij+d (d = drain count). Exit EXEC when d=len_nij and both fetch and rd counts are done.
- SFP, per pixel o<len_nij:
  - Read psum_addr=k*len_nij+o for k=0..len_kij-1, one per cycle.
  - sfu_acc_en is each read delayed 1 cycle.
  - sfu_write_en 1 cycle after the last acc_en.
  - out_wr with out_addr=o 1 cycle after write_en.
  - Next pixel reads may start the cycle after the last read (pipelined).
- FIN: done=1 for one cycle, busy falls the same cycle.
- Address arithmetic is unsigned. Truncation to the port widths is the user's responsibility: require len_kij*len_nij ≤ 2^p_addr_bw.

Optional Feature:
CORELET_CTRL_PERF_EN — when defined, adds outputs cyc_cnt[31:0] (busy cycles) and stall_cnt[31:0] (cycles the skid register is held or l0_rd is blocked by !l0_ready). Both clear on accepted start and saturate. Absent: no ports, no logic.

Test Plan:
- Reset mid-EXEC at kij=3 → same cycle all outputs 0, busy=0. A new start runs the full layer with no done before completion.
- Nominal 8x8 run, len_kij=9, len_nij=36, l0_full tied 0 → exactly 72 weight and 324 activation writes, 324 psum writes at addresses 0..323, 36 out_wr at 0..35, one done.
- l0_full forced high 3 cycles mid-LD_W → no word lost or duplicated; L0 receives addresses kij*8+0..7 in order.
- ofifo_valid toggling every other cycle → psum addresses strictly consecutive, ofifo_rd never high while ofifo_valid=0.
- Known psum pattern (all tiles = -1 for o even, +2 otherwise) → out pixel is 0 for even o, 18 for odd o; sfu_acc_en count = 9 per pixel.
- start pulsed while busy → ignored; done count stays 1.
